// File: rtl/dec24.sv
// rtl/dec24.sv - registered N-to-2**N line decoder with enable and valid flag
// Q is one-hot (or one-cold when ACTIVE_LOW) while valid, otherwise the idle pattern.
module dec24 #(
  parameter int IN_W       = 2,
  parameter int OUT_W      = 2 ** IN_W,
  parameter int ACTIVE_LOW = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [IN_W-1:0]  I,
  output logic [OUT_W-1:0] Q,
  output logic             valid
);

  localparam logic [OUT_W-1:0] IDLE_PAT = (ACTIVE_LOW != 0) ? {OUT_W{1'b1}} : {OUT_W{1'b0}};

  logic [OUT_W-1:0] onehot;
  logic [OUT_W-1:0] q_d, q_q;
  logic             valid_d, valid_q;

  always_comb begin
    onehot    = '0;
    onehot[I] = 1'b1;
    q_d       = IDLE_PAT;
    valid_d   = 1'b0;
    if (en) begin
      q_d     = (ACTIVE_LOW != 0) ? ~onehot : onehot;
      valid_d = 1'b1;
    end
  end

  // Reset wins over en and I; disable drops to idle rather than holding.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q     <= IDLE_PAT;
      valid_q <= 1'b0;
    end else begin
      q_q     <= q_d;
      valid_q <= valid_d;
    end
  end

  assign Q     = q_q;
  assign valid = valid_q;

endmodule

// File: tb/tb_dec24.sv
// tb/tb_dec24.sv - self-checking bench for dec24 (default 2:4 and ACTIVE_LOW 3:8)
module tb_dec24;

  logic       clk;
  logic       rst, en;
  logic [1:0] I;
  logic [3:0] Q;
  logic       valid;
  logic       rst1, en1;
  logic [2:0] I1;
  logic [7:0] Q1;
  logic       valid1;

  int checks;
  int errors;

  dec24 dut (
    .clk(clk), .rst(rst), .en(en), .I(I), .Q(Q), .valid(valid)
  );

  dec24 #(.IN_W(3), .ACTIVE_LOW(1)) dut_al (
    .clk(clk), .rst(rst1), .en(en1), .I(I1), .Q(Q1), .valid(valid1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Line k of a 2**n decoder is asserted iff the sampled select equals k.
  function automatic logic [3:0] ref_q(input bit r, input bit e, input int sel);
    logic [3:0] v;
    v = '0;
    if (!r && e) v = 4'(1) << sel;
    return v;
  endfunction

  function automatic logic [7:0] ref_q_al(input bit r, input bit e, input int sel);
    logic [7:0] v;
    v = 8'hFF;
    if (!r && e) v = ~(8'(1) << sel);
    return v;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1; en = 1; I = 2;
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++;
      if (Q !== 4'b0000 || valid !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold cyc %0d got Q=%b valid=%b exp Q=0000 valid=0", c, Q, valid);
      end
    end
    rst = 0;
    tick();
    checks++;
    if (Q !== 4'b0100 || valid !== 1'b1) begin
      errors++;
      $display("FAIL reset_release got Q=%b valid=%b exp Q=0100 valid=1", Q, valid);
    end
  endtask

  task automatic test_sweep;
    en = 1;
    for (int s = 0; s < 4; s++) begin
      I = 2'(s);
      for (int c = 0; c < 10; c++) begin
        tick();
        checks++;
        if (Q !== ref_q(0, 1, s) || valid !== 1'b1) begin
          errors++;
          $display("FAIL sweep I=%0d cyc %0d got Q=%b valid=%b exp Q=%b valid=1",
                   s, c, Q, valid, ref_q(0, 1, s));
        end
      end
    end
  endtask

  task automatic test_disable;
    logic       en_seq [3];
    logic [3:0] exp_q;
    en_seq = '{1'b1, 1'b0, 1'b1};
    I = 3;
    for (int k = 0; k < 3; k++) begin
      en = en_seq[k];
      tick();
      exp_q = ref_q(0, en_seq[k], 3);
      checks++;
      if (Q !== exp_q || valid !== en_seq[k]) begin
        errors++;
        $display("FAIL disable step %0d got Q=%b valid=%b exp Q=%b valid=%b",
                 k, Q, valid, exp_q, en_seq[k]);
      end
    end
  endtask

  task automatic test_back_to_back;
    int         seq [4];
    logic [3:0] prev_q;
    seq = '{3, 0, 1, 2};
    en = 1;
    for (int k = 0; k < 4; k++) begin
      prev_q = Q;
      I = 2'(seq[k]);
      #1;
      checks++;
      if (Q !== prev_q) begin
        errors++;
        $display("FAIL b2b_no_comb_path step %0d got Q=%b exp Q=%b", k, Q, prev_q);
      end
      tick();
      checks++;
      if (Q !== ref_q(0, 1, seq[k]) || !$onehot(Q) || valid !== 1'b1) begin
        errors++;
        $display("FAIL b2b step %0d got Q=%b valid=%b exp Q=%b valid=1",
                 k, Q, valid, ref_q(0, 1, seq[k]));
      end
    end
  endtask

  task automatic test_mid_reset;
    en = 1; I = 1;
    tick();
    rst = 1;
    tick();
    checks++;
    if (Q !== 4'b0000 || valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset got Q=%b valid=%b exp Q=0000 valid=0", Q, valid);
    end
    rst = 0;
    tick();
    checks++;
    if (Q !== 4'b0010 || valid !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_release got Q=%b valid=%b exp Q=0010 valid=1", Q, valid);
    end
  endtask

  task automatic test_active_low;
    rst1 = 1; en1 = 1; I1 = 5;
    tick();
    checks++;
    if (Q1 !== 8'hFF || valid1 !== 1'b0) begin
      errors++;
      $display("FAIL al_reset got Q=%b valid=%b exp Q=11111111 valid=0", Q1, valid1);
    end
    rst1 = 0;
    tick();
    checks++;
    if (Q1 !== 8'b11011111 || valid1 !== 1'b1) begin
      errors++;
      $display("FAIL al_decode5 got Q=%b valid=%b exp Q=11011111 valid=1", Q1, valid1);
    end
    for (int s = 0; s < 8; s++) begin
      I1 = 3'(s);
      tick();
      checks++;
      if (Q1 !== ref_q_al(0, 1, s) || valid1 !== 1'b1) begin
        errors++;
        $display("FAIL al_sweep I=%0d got Q=%b valid=%b exp Q=%b valid=1",
                 s, Q1, valid1, ref_q_al(0, 1, s));
      end
    end
    rst1 = 1;
    tick();
    checks++;
    if (Q1 !== 8'hFF || valid1 !== 1'b0) begin
      errors++;
      $display("FAIL al_reset_again got Q=%b valid=%b exp Q=11111111 valid=0", Q1, valid1);
    end
    rst1 = 0;
  endtask

  task automatic test_random;
    bit r, e, r1, e1;
    int s, s1;
    for (int n = 0; n < 300; n++) begin
      r  = ($urandom % 12) == 0;
      e  = ($urandom % 4) != 0;
      s  = int'($urandom % 4);
      r1 = ($urandom % 12) == 0;
      e1 = ($urandom % 3) != 0;
      s1 = int'($urandom % 8);
      rst = r; en = e; I = 2'(s);
      rst1 = r1; en1 = e1; I1 = 3'(s1);
      tick();
      checks++;
      if (Q !== ref_q(r, e, s) || valid !== (!r && e)) begin
        errors++;
        $display("FAIL random n=%0d rst=%0b en=%0b I=%0d got Q=%b valid=%b exp Q=%b valid=%b",
                 n, r, e, s, Q, valid, ref_q(r, e, s), (!r && e));
      end
      checks++;
      if (Q1 !== ref_q_al(r1, e1, s1) || valid1 !== (!r1 && e1)) begin
        errors++;
        $display("FAIL random_al n=%0d rst=%0b en=%0b I=%0d got Q=%b valid=%b exp Q=%b valid=%b",
                 n, r1, e1, s1, Q1, valid1, ref_q_al(r1, e1, s1), (!r1 && e1));
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1; en = 0; I = 0;
    rst1 = 1; en1 = 0; I1 = 0;
    #1;
    test_reset();
    test_sweep();
    test_disable();
    test_back_to_back();
    test_mid_reset();
    test_active_low();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
